// File: rtl/connect_turn_fsm.sv
// ---------------------------------------------------------------------------
// connect_turn_fsm
//
// Game-control FSM for a Connect-N board. Hands turns round NUM_PLAYERS
// players, asks for a rethrow when a piece is dropped into a full column,
// forfeits a turn when the optional per-turn timer expires, and declares a
// win or a tie. The opening player rotates from one game to the next.
//
// Ports
//   clk           in   clock
//   reset         in   asynchronous, active-high reset
//   start         in   one-cycle pulse; begins a new game from IDLE or END
//   move_valid    in   one-cycle pulse; current player dropped a piece
//   move_ok       in   qualifies move_valid; 0 = column full (illegal move)
//   win_detect    in   win detector result, sampled only in CHECK
//   state         out  00 IDLE, 01 TURN, 10 CHECK, 11 END
//   cur_player    out  index of the player whose turn it is
//   game_status   out  00 playing/idle, 01 win, 10 tie
//   winner        out  winning player, meaningful when game_status = 01
//   move_count    out  accepted moves in the current game
//   throw_again   out  one-cycle pulse: illegal move, same player again
//   turn_skipped  out  one-cycle pulse: turn forfeited by timeout
// ---------------------------------------------------------------------------
module connect_turn_fsm #(
  parameter int NUM_PLAYERS    = 2,
  parameter int PLAYER_W       = 3,
  parameter int MAX_MOVES      = 42,
  parameter int MOVE_W         = 6,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int TMR_W          = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                move_valid,
  input  logic                move_ok,
  input  logic                win_detect,
  output logic [1:0]          state,
  output logic [PLAYER_W-1:0] cur_player,
  output logic [1:0]          game_status,
  output logic [PLAYER_W-1:0] winner,
  output logic [MOVE_W-1:0]   move_count,
  output logic                throw_again,
  output logic                turn_skipped
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_TURN  = 2'b01,
    ST_CHECK = 2'b10,
    ST_END   = 2'b11
  } state_t;

  localparam logic [1:0] GS_PLAY = 2'b00;
  localparam logic [1:0] GS_WIN  = 2'b01;
  localparam logic [1:0] GS_TIE  = 2'b10;

  localparam logic [PLAYER_W-1:0] LAST_PLAYER = PLAYER_W'(NUM_PLAYERS - 1);
  localparam logic [MOVE_W-1:0]   LAST_MOVE   = MOVE_W'(MAX_MOVES);
  localparam bit                  TMO_EN      = (TIMEOUT_CYCLES > 0);
  // Timer value seen in the final allowed cycle of a turn; unused when the
  // timeout is disabled.
  localparam logic [TMR_W-1:0]    TMO_LAST    =
    (TIMEOUT_CYCLES > 0) ? TMR_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [TMR_W-1:0]    TMR_MAX     = '1;

  state_t                state_q,        state_d;
  logic [PLAYER_W-1:0]   cur_player_q,   cur_player_d;
  logic [PLAYER_W-1:0]   first_player_q, first_player_d;
  logic [1:0]            game_status_q,  game_status_d;
  logic [PLAYER_W-1:0]   winner_q,       winner_d;
  logic [MOVE_W-1:0]     move_count_q,   move_count_d;
  logic [TMR_W-1:0]      timer_q,        timer_d;
  logic                  throw_again_q,  throw_again_d;
  logic                  turn_skipped_q, turn_skipped_d;

  // Round-robin advance; indices at or above NUM_PLAYERS are never produced.
  function automatic logic [PLAYER_W-1:0] next_player(input logic [PLAYER_W-1:0] p);
    return (p == LAST_PLAYER) ? '0 : p + PLAYER_W'(1);
  endfunction

  // ------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      cur_player_q   <= '0;
      first_player_q <= '0;
      game_status_q  <= GS_PLAY;
      winner_q       <= '0;
      move_count_q   <= '0;
      timer_q        <= '0;
      throw_again_q  <= 1'b0;
      turn_skipped_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      cur_player_q   <= cur_player_d;
      first_player_q <= first_player_d;
      game_status_q  <= game_status_d;
      winner_q       <= winner_d;
      move_count_q   <= move_count_d;
      timer_q        <= timer_d;
      throw_again_q  <= throw_again_d;
      turn_skipped_q <= turn_skipped_d;
    end
  end

  // ------------------------------------------------------------------
  // Next-state logic
  // ------------------------------------------------------------------
  always_comb begin
    state_d        = state_q;
    cur_player_d   = cur_player_q;
    first_player_d = first_player_q;
    game_status_d  = game_status_q;
    winner_d       = winner_q;
    move_count_d   = move_count_q;
    timer_d        = timer_q;
    throw_again_d  = 1'b0;
    turn_skipped_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d       = ST_TURN;
          cur_player_d  = first_player_q;
          move_count_d  = '0;
          timer_d       = '0;
          game_status_d = GS_PLAY;
          winner_d      = '0;
        end
      end

      ST_TURN: begin
        // A move in the same cycle the timer runs out still counts.
        if (move_valid) begin
          timer_d = '0;
          if (move_ok) begin
            state_d      = ST_CHECK;
            move_count_d = move_count_q + MOVE_W'(1);
          end else begin
            throw_again_d = 1'b1;
          end
        end else if (TMO_EN && (timer_q == TMO_LAST)) begin
          turn_skipped_d = 1'b1;
          cur_player_d   = next_player(cur_player_q);
          timer_d        = '0;
        end else if (timer_q != TMR_MAX) begin
          timer_d = timer_q + TMR_W'(1);
        end
      end

      ST_CHECK: begin
        // Win is tested before the board-full test so a winning last
        // piece reports a win rather than a tie.
        if (win_detect) begin
          state_d       = ST_END;
          game_status_d = GS_WIN;
          winner_d      = cur_player_q;
        end else if (move_count_q == LAST_MOVE) begin
          state_d       = ST_END;
          game_status_d = GS_TIE;
        end else begin
          state_d      = ST_TURN;
          cur_player_d = next_player(cur_player_q);
        end
      end

      ST_END: begin
        if (start) begin
          // Rotate the opener so consecutive games start with different
          // players.
          first_player_d = next_player(first_player_q);
          state_d        = ST_TURN;
          cur_player_d   = next_player(first_player_q);
          move_count_d   = '0;
          timer_d        = '0;
          game_status_d  = GS_PLAY;
          winner_d       = '0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign state        = state_q;
  assign cur_player   = cur_player_q;
  assign game_status  = game_status_q;
  assign winner       = winner_q;
  assign move_count   = move_count_q;
  assign throw_again  = throw_again_q;
  assign turn_skipped = turn_skipped_q;

endmodule

// File: tb/tb_connect_turn_fsm.sv
// ---------------------------------------------------------------------------
// tb_connect_turn_fsm
//
// Two instances share one stimulus stream: dut0 is the default two-player
// game with no timeout, dut1 is a three-player game with a 5-cycle move
// timeout. A game-rules model per instance predicts every output; a
// directed opening with literal expectations is followed by random play.
// ---------------------------------------------------------------------------
module tb_connect_turn_fsm;

  localparam int MAXM = 42;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic move_valid = 1'b0;
  logic move_ok = 1'b0;
  logic win_detect = 1'b0;

  logic [1:0] st0, gs0, st1, gs1;
  logic [2:0] cp0, wn0, cp1, wn1;
  logic [5:0] mc0, mc1;
  logic       ta0, ts0, ta1, ts1;

  always #5 clk = ~clk;

  connect_turn_fsm #(.NUM_PLAYERS(2), .TIMEOUT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .move_valid(move_valid),
    .move_ok(move_ok), .win_detect(win_detect), .state(st0),
    .cur_player(cp0), .game_status(gs0), .winner(wn0), .move_count(mc0),
    .throw_again(ta0), .turn_skipped(ts0)
  );

  connect_turn_fsm #(.NUM_PLAYERS(3), .TIMEOUT_CYCLES(5)) dut1 (
    .clk(clk), .reset(reset), .start(start), .move_valid(move_valid),
    .move_ok(move_ok), .win_detect(win_detect), .state(st1),
    .cur_player(cp1), .game_status(gs1), .winner(wn1), .move_count(mc1),
    .throw_again(ta1), .turn_skipped(ts1)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // ---------------- game-rules model ----------------
  // phase: 0 idle, 1 waiting for a move, 2 judging a move, 3 game over
  typedef struct packed {
    int phase;
    int player;
    int first;
    int moves;
    int status;
    int winner;
    int waited;   // cycles the current player has been waiting
    bit rethrow;
    bit skipped;
  } game_t;

  function automatic game_t fresh();
    game_t g;
    g = '0;
    return g;
  endfunction

  function automatic game_t new_game(input game_t g, input int opener);
    game_t n = g;
    n.phase  = 1;
    n.player = opener;
    n.moves  = 0;
    n.status = 0;
    n.waited = 0;
    return n;
  endfunction

  function automatic game_t rules(input game_t g, input int np, input int tmo,
                                  input bit s, input bit mv, input bit ok,
                                  input bit wd);
    game_t n = g;
    n.rethrow = 1'b0;
    n.skipped = 1'b0;
    if (g.phase == 0) begin
      if (s) n = new_game(n, g.first);
    end else if (g.phase == 1) begin
      if (mv) begin
        n.waited = 0;
        if (ok) begin
          n.phase = 2;
          n.moves = g.moves + 1;
        end else begin
          n.rethrow = 1'b1;
        end
      end else if (tmo > 0 && g.waited + 1 >= tmo) begin
        n.skipped = 1'b1;
        n.player  = (g.player + 1) % np;
        n.waited  = 0;
      end else begin
        n.waited = g.waited + 1;
      end
    end else if (g.phase == 2) begin
      if (wd) begin
        n.phase  = 3;
        n.status = 1;
        n.winner = g.player;
      end else if (g.moves == MAXM) begin
        n.phase  = 3;
        n.status = 2;
      end else begin
        n.phase  = 1;
        n.player = (g.player + 1) % np;
      end
    end else begin
      if (s) begin
        n.first = (g.first + 1) % np;
        n = new_game(n, (g.first + 1) % np);
      end
    end
    return n;
  endfunction

  game_t m0, m1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m0 <= fresh();
      m1 <= fresh();
    end else begin
      m0 <= rules(m0, 2, 0, start, move_valid, move_ok, win_detect);
      m1 <= rules(m1, 3, 5, start, move_valid, move_ok, win_detect);
    end
  end

  // ---------------- checking ----------------
  task automatic cmp(input string name, input int inst, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t: got %0d want %0d", name, inst, $time, act, exp);
    end
  endtask

  task automatic check_inst(input int inst, input game_t m, input int st, input int cp,
                            input int gs, input int wn, input int mc,
                            input int ta, input int ts);
    cmp("state", inst, st, m.phase);
    cmp("cur_player", inst, cp, m.player);
    cmp("game_status", inst, gs, m.status);
    if (m.status == 1) cmp("winner", inst, wn, m.winner);
    cmp("move_count", inst, mc, m.moves);
    cmp("throw_again", inst, ta, int'(m.rethrow));
    cmp("turn_skipped", inst, ts, int'(m.skipped));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_inst(0, m0, int'(st0), int'(cp0), int'(gs0), int'(wn0), int'(mc0),
                 int'(ta0), int'(ts0));
      check_inst(1, m1, int'(st1), int'(cp1), int'(gs1), int'(wn1), int'(mc1),
                 int'(ta1), int'(ts1));
    end
  end

  // One cycle of stimulus: inputs held across one rising edge, then idle.
  task automatic cyc(input bit s, input bit mv, input bit ok, input bit wd);
    start = s; move_valid = mv; move_ok = ok; win_detect = wd;
    @(posedge clk);
    #2;
    start = 1'b0; move_valid = 1'b0; move_ok = 1'b0; win_detect = 1'b0;
  endtask

  initial begin
    // ---- reset state ----
    @(posedge clk);
    #2;
    cmp("rst_state", 0, int'(st0), 0);
    cmp("rst_cur", 0, int'(cp0), 0);
    cmp("rst_status", 0, int'(gs0), 0);
    cmp("rst_winner", 0, int'(wn0), 0);
    cmp("rst_count", 0, int'(mc0), 0);
    cmp("rst_pulses", 0, int'(ta0) + int'(ts0), 0);
    reset = 1'b0;
    chk_en = 1'b1;

    // ---- first game: legal moves and a rethrow ----
    cyc(1, 0, 0, 0);
    cmp("start_state", 0, int'(st0), 1);
    cmp("start_cur", 0, int'(cp0), 0);
    cyc(0, 1, 1, 0);
    cmp("move_check", 0, int'(st0), 2);
    cmp("move_count1", 0, int'(mc0), 1);
    cyc(0, 0, 0, 0);
    cmp("p1_turn", 0, int'(st0), 1);
    cmp("p1_cur", 0, int'(cp0), 1);
    cyc(0, 1, 0, 0);
    cmp("rethrow_pulse", 0, int'(ta0), 1);
    cmp("rethrow_state", 0, int'(st0), 1);
    cmp("rethrow_cur", 0, int'(cp0), 1);
    cmp("rethrow_count", 0, int'(mc0), 1);
    cyc(0, 0, 0, 0);
    cmp("rethrow_one_cycle", 0, int'(ta0), 0);
    cyc(0, 1, 1, 0);
    cyc(0, 0, 0, 0);
    cmp("back_to_p0", 0, int'(cp0), 0);
    cmp("count2", 0, int'(mc0), 2);
    cmp("three_way_p2", 1, int'(cp1), 2);
    cyc(0, 1, 1, 0);
    cyc(0, 0, 0, 0);
    cmp("three_way_wrap", 1, int'(cp1), 0);

    // ---- timeout on dut1 ----
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0);
      cmp("no_skip_yet", 1, int'(ts1), 0);
    end
    cyc(0, 0, 0, 0);
    cmp("skip_pulse", 1, int'(ts1), 1);
    cmp("skip_advance", 1, int'(cp1), 1);
    cmp("skip_stay_turn", 1, int'(st1), 1);
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, 0);
      cmp("no_skip_again", 1, int'(ts1), 0);
    end
    cyc(0, 1, 1, 0);
    cmp("move_beats_timeout", 1, int'(st1), 2);
    cmp("no_skip_on_move", 1, int'(ts1), 0);
    cyc(0, 0, 0, 1);
    cmp("win_state", 0, int'(st0), 3);
    cmp("win_status", 0, int'(gs0), 1);
    cmp("win_player", 0, int'(wn0), 1);
    cmp("win_player", 1, int'(wn1), 1);
    cmp("win_count", 0, int'(mc0), 4);
    cyc(0, 1, 1, 0);
    cmp("end_ignores_move", 0, int'(st0), 3);

    // ---- rotation of opener, then a full-board tie ----
    cyc(1, 0, 0, 0);
    cmp("rot_cur", 0, int'(cp0), 1);
    cmp("rot_count", 0, int'(mc0), 0);
    cmp("rot_state", 0, int'(st0), 1);
    for (int i = 0; i < MAXM; i++) begin
      cyc(0, 1, 1, 0);
      cyc(0, 0, 0, 0);
    end
    cmp("tie_state", 0, int'(st0), 3);
    cmp("tie_status", 0, int'(gs0), 2);
    cmp("tie_count", 0, int'(mc0), MAXM);

    // ---- win on the final cell ----
    cyc(1, 0, 0, 0);
    cmp("rot2_cur", 0, int'(cp0), 0);
    for (int i = 0; i < MAXM; i++) begin
      cyc(0, 1, 1, 0);
      cyc(0, 0, 0, (i == MAXM - 1));
    end
    cmp("last_cell_win", 0, int'(gs0), 1);
    cmp("last_cell_count", 0, int'(mc0), MAXM);

    // ---- reset while in CHECK ----
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 0);
    cmp("pre_reset_check", 0, int'(st0), 2);
    reset = 1'b1;
    #1;
    cmp("areset_state", 0, int'(st0), 0);
    cmp("areset_cur", 0, int'(cp0), 0);
    cmp("areset_count", 0, int'(mc0), 0);
    cmp("areset_status", 0, int'(gs0), 0);
    cmp("areset_state", 1, int'(st1), 0);
    cyc(1, 1, 1, 1);
    reset = 1'b0;
    cyc(1, 0, 0, 0);
    cmp("opener_reset", 0, int'(cp0), 0);

    // ---- random play ----
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(399) == 0) begin
        reset = 1'b1;
        cyc(0, 0, 0, 0);
        reset = 1'b0;
      end else begin
        cyc(($urandom_range(5) == 0), ($urandom_range(2) == 0),
            ($urandom_range(3) != 0), ($urandom_range(9) == 0));
      end
    end

    chk_en = 1'b0;
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
